// File: rtl/ext_mem_ws.sv
// External-memory model with programmable wait states.
// A strobe sampled in IDLE yields exactly one registered mem_ready pulse after WAIT_STATES extra cycles.
module ext_mem_ws #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 65536,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_wr_n,
  input  logic              mem_rd_n,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_ready,
  output logic              mem_err
);

  // Handshake: a request is any low strobe seen in IDLE; address, data and type are
  // captured on that edge, mem_ready (with mem_err) is high for the single ACK cycle,
  // and a new request is only accepted once both strobes have been seen high in HOLD.

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              lat_wr;
  logic              lat_rd;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              req;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_wr;
  logic              sel_rd;
  logic              in_range;
  logic              go_ack;
  logic              acc_err;
  logic              do_wr;
  logic              do_rd;
  logic [IDX_W-1:0]  idx;

  // With zero wait states the access completes on the sampling edge itself,
  // so the live inputs are used instead of the not-yet-latched copies.
  always_comb begin
    req      = !mem_rd_n || !mem_wr_n;
    sel_addr = lat_addr;
    sel_data = lat_data;
    sel_wr   = lat_wr;
    sel_rd   = lat_rd;
    if (state == IDLE) begin
      sel_addr = mem_addr;
      sel_data = mem_data_in;
      sel_wr   = !mem_wr_n;
      sel_rd   = !mem_rd_n;
    end
    in_range = {1'b0, sel_addr} < DEPTH_L;
    idx      = sel_addr[IDX_W-1:0];
    go_ack   = ((state == IDLE) && req && (WAIT_STATES == 0)) ||
               ((state == WAIT) && (cnt == 4'd0));
    acc_err  = (sel_wr && sel_rd) || !in_range;
    do_wr    = go_ack && sel_wr && !sel_rd && in_range;
    do_rd    = go_ack && sel_rd && !sel_wr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      lat_addr     <= '0;
      lat_data     <= '0;
      lat_wr       <= 1'b0;
      lat_rd       <= 1'b0;
      mem_ready    <= 1'b0;
      mem_err      <= 1'b0;
      mem_data_out <= '0;
    end else begin
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            lat_addr <= mem_addr;
            lat_data <= mem_data_in;
            lat_wr   <= !mem_wr_n;
            lat_rd   <= !mem_rd_n;
            if (WAIT_STATES == 0) begin
              state <= ACK;
            end else begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= ACK;
          else             cnt   <= cnt - 4'd1;
        end
        ACK:  state <= HOLD;
        HOLD: if (mem_rd_n && mem_wr_n) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (go_ack) begin
        mem_ready <= 1'b1;
        mem_err   <= acc_err;
        if (do_rd) mem_data_out <= in_range ? mem[idx] : '1;
      end
    end
  end

  // Array has no reset; reset forces IDLE so an in-flight write never commits.
  always_ff @(posedge clk) begin
    if (do_wr) mem[idx] <= sel_data;
  end

endmodule

// File: tb/tb_ext_mem_ws.sv
// Bench for ext_mem_ws: directed vector table, multi-cycle corner sequences,
// and randomized accesses checked against a simple memory model.
module tb_ext_mem_ws;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_in;
  logic        mem_wr_n;
  logic        mem_rd_n;
  logic [7:0]  mem_data_out;
  logic        mem_ready;
  logic        mem_err;

  logic [15:0] b_addr;
  logic [7:0]  b_data_in;
  logic        b_wr_n;
  logic        b_rd_n;
  logic [7:0]  b_data_out;
  logic        b_ready;
  logic        b_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] ref_mem [1024];
  logic [7:0] model_dout;

  always #5 clk = ~clk;

  ext_mem_ws #(.DATA_W(8), .ADDR_W(16), .DEPTH(1024), .WAIT_STATES(2)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_wr_n(mem_wr_n), .mem_rd_n(mem_rd_n), .mem_data_out(mem_data_out),
    .mem_ready(mem_ready), .mem_err(mem_err)
  );

  ext_mem_ws #(.DATA_W(8), .ADDR_W(16), .DEPTH(1024), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .mem_addr(b_addr), .mem_data_in(b_data_in),
    .mem_wr_n(b_wr_n), .mem_rd_n(b_rd_n), .mem_data_out(b_data_out),
    .mem_ready(b_ready), .mem_err(b_err)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        exp_err;
    logic [7:0]  exp_dout;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Memory model: expected error flag and expected read-data register.
  task automatic model_op(input logic wr, input logic rd, input logic [15:0] addr,
                          input logic [7:0] data, output logic exp_err);
    exp_err = (wr && rd) || (addr >= 16'd1024);
    if (!(wr && rd)) begin
      if (wr && addr < 16'd1024) ref_mem[addr[9:0]] = data;
      if (rd) model_dout = (addr < 16'd1024) ? ref_mem[addr[9:0]] : 8'hFF;
    end
  endtask

  task automatic wait_ack(output int lat, output logic [7:0] dout, output logic err);
    lat  = -1;
    dout = '0;
    err  = 1'b0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (mem_ready) begin
        lat  = c;
        dout = mem_data_out;
        err  = mem_err;
      end else begin
        check("err_without_ready", 32'(mem_err), 32'd0);
      end
      if (c == 1) begin
        mem_addr    = 16'($urandom);
        mem_data_in = 8'($urandom);
      end
    end
    mem_wr_n = 1'b1;
    mem_rd_n = 1'b1;
    @(posedge clk); #1;
    check("ready_one_cycle", 32'(mem_ready), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_access(input logic wr, input logic rd, input logic [15:0] addr,
                           input logic [7:0] data, output int lat,
                           output logic [7:0] dout, output logic err);
    mem_addr    = addr;
    mem_data_in = data;
    mem_wr_n    = !wr;
    mem_rd_n    = !rd;
    wait_ack(lat, dout, err);
  endtask

  task automatic model_access(input string name, input logic wr, input logic rd,
                              input logic [15:0] addr, input logic [7:0] data);
    logic       e_err;
    int         lat;
    logic [7:0] dout;
    logic       err;
    model_op(wr, rd, addr, data, e_err);
    do_access(wr, rd, addr, data, lat, dout, err);
    check({name, "_lat"},  32'(lat),  32'd3);
    check({name, "_err"},  32'(err),  32'(e_err));
    check({name, "_dout"}, 32'(dout), 32'(model_dout));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         lat;
    logic [7:0] dout;
    logic       err;
    logic       e_err;
    int         pulses;

    tbl[0]  = '{1'b1, 1'b0, 16'h0010, 8'hA5, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 16'h0010, 8'h00, 1'b0, 8'hA5};
    tbl[2]  = '{1'b1, 1'b0, 16'h0000, 8'h5A, 1'b0, 8'hA5};
    tbl[3]  = '{1'b0, 1'b1, 16'h0400, 8'h00, 1'b1, 8'hFF};
    tbl[4]  = '{1'b1, 1'b0, 16'h0400, 8'h77, 1'b1, 8'hFF};
    tbl[5]  = '{1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 8'h5A};
    tbl[6]  = '{1'b1, 1'b0, 16'h0020, 8'hC3, 1'b0, 8'h5A};
    tbl[7]  = '{1'b1, 1'b1, 16'h0020, 8'h00, 1'b1, 8'h5A};
    tbl[8]  = '{1'b0, 1'b1, 16'h0020, 8'h00, 1'b0, 8'hC3};
    tbl[9]  = '{1'b0, 1'b1, 16'h0410, 8'h00, 1'b1, 8'hFF};
    tbl[10] = '{1'b1, 1'b0, 16'h03FF, 8'h12, 1'b0, 8'hFF};
    tbl[11] = '{1'b0, 1'b1, 16'h03FF, 8'h00, 1'b0, 8'h12};

    // Clock/reset
    rst_n = 1'b0;
    mem_addr = '0; mem_data_in = '0; mem_wr_n = 1'b1; mem_rd_n = 1'b1;
    b_addr = '0; b_data_in = '0; b_wr_n = 1'b1; b_rd_n = 1'b1;
    model_dout = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(mem_ready), 32'd0);
    check("reset_err",   32'(mem_err),   32'd0);
    check("reset_dout",  32'(mem_data_out), 32'd0);
    check("reset_dout_ws0", 32'(b_data_out), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      model_op(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data, e_err);
      do_access(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data, lat, dout, err);
      check($sformatf("vec%0d_lat", i),  32'(lat),  32'd3);
      check($sformatf("vec%0d_err", i),  32'(err),  32'(tbl[i].exp_err));
      check($sformatf("vec%0d_dout", i), 32'(dout), 32'(tbl[i].exp_dout));
    end

    // Zero wait states: ready on the cycle after the sampling edge
    b_addr = 16'h0010; b_data_in = 8'h3C; b_wr_n = 1'b0;
    @(posedge clk); #1;
    check("ws0_wr_ready", 32'(b_ready), 32'd1);
    check("ws0_wr_err",   32'(b_err),   32'd0);
    b_wr_n = 1'b1; b_data_in = 8'h00;
    @(posedge clk); #1;
    check("ws0_wr_ready_drop", 32'(b_ready), 32'd0);
    @(posedge clk); #1;
    b_rd_n = 1'b0;
    @(posedge clk); #1;
    check("ws0_rd_ready", 32'(b_ready),    32'd1);
    check("ws0_rd_dout",  32'(b_data_out), 32'h3C);
    check("ws0_rd_err",   32'(b_err),      32'd0);
    b_rd_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Fill a low window with random data, then random traffic against the model
    for (int a = 0; a < 64; a++)
      model_access("init_wr", 1'b1, 1'b0, 16'(a), 8'($urandom));
    for (int n = 0; n < 60; n++) begin
      int          kind;
      logic [15:0] addr;
      kind = $urandom_range(0, 9);
      addr = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(1024, 65535))
                                         : 16'($urandom_range(0, 63));
      model_access($sformatf("rand%0d", n), (kind >= 4), (kind <= 3) || (kind >= 8),
                   addr, 8'($urandom));
    end

    // Held read strobe gives one pulse; re-assert gives another
    model_op(1'b0, 1'b1, 16'h0010, 8'h00, e_err);
    mem_addr = 16'h0010; mem_rd_n = 1'b0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (mem_ready) pulses++;
    end
    check("hold_pulses", 32'(pulses), 32'd1);
    check("hold_dout",   32'(mem_data_out), 32'(model_dout));
    mem_rd_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_rd_n = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (mem_ready) pulses++;
    end
    check("reassert_pulses", 32'(pulses), 32'd1);
    mem_rd_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset during WAIT aborts a write; strobe held through reset is a new request
    model_access("rst_pre_wr", 1'b1, 1'b0, 16'h0030, 8'h11);
    model_access("rst_pre_rd", 1'b0, 1'b1, 16'h03FF, 8'h00);
    mem_addr = 16'h0030; mem_data_in = 8'h99; mem_wr_n = 1'b0; mem_rd_n = 1'b1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_dout",  32'(mem_data_out), 32'd0);
    check("rst_async_ready", 32'(mem_ready),    32'd0);
    check("rst_async_err",   32'(mem_err),      32'd0);
    mem_wr_n = 1'b1; mem_rd_n = 1'b0; mem_addr = 16'h0030;
    @(posedge clk);
    #3 rst_n = 1'b1;
    model_dout = 8'h00;
    model_op(1'b0, 1'b1, 16'h0030, 8'h00, e_err);
    wait_ack(lat, dout, err);
    check("post_rst_lat",  32'(lat),  32'd3);
    check("post_rst_err",  32'(err),  32'd0);
    check("post_rst_dout", 32'(dout), 32'h11);
    check("post_rst_model", 32'(dout), 32'(model_dout));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ext_mem_ws.md
EXT_MEM_WS -- requirements
Module: ext_mem_ws

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bus width in bits.
REQ-002 SHALL have parameter ADDR_W, default 16, address bus width in bits.
REQ-003 SHALL have parameter DEPTH, default 65536, number of implemented words; legal range 1..2^ADDR_W.
REQ-004 SHALL have parameter WAIT_STATES, default 2, extra cycles inserted before an access completes; legal range 0..15.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port mem_addr  input  ADDR_W  access address.
REQ-008 SHALL have port mem_data_in  input  DATA_W  write data.
REQ-009 SHALL have port mem_wr_n  input  1  write strobe, active-low, level.
REQ-010 SHALL have port mem_rd_n  input  1  read strobe, active-low, level.
REQ-011 SHALL have port mem_data_out  output  DATA_W  registered read data.
REQ-012 SHALL have port mem_ready  output  1  access-complete pulse, registered.
REQ-013 SHALL have port mem_err  output  1  access-error flag, valid only while mem_ready=1.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, ACK, HOLD.
REQ-015 In IDLE, SHALL sample a request at edge k when mem_rd_n=0 or mem_wr_n=0; SHALL latch mem_addr, mem_data_in and access type at that edge.
REQ-016 At edge k, SHALL go to WAIT with a counter loaded to WAIT_STATES-1 if WAIT_STATES>0, else directly to ACK.
REQ-017 In WAIT, SHALL decrement the counter each edge; SHALL go to ACK on the edge where the counter equals 0.
REQ-018 mem_ready SHALL be 1 for exactly one cycle (the ACK cycle), beginning after edge k+WAIT_STATES; latency = WAIT_STATES+1 cycles from the sampling edge.
REQ-019 Write SHALL commit the latched data into the array on the edge entering ACK.
REQ-020 Read SHALL load mem_data_out on the edge entering ACK; mem_data_out SHALL hold until the next completed read or reset.
REQ-021 From ACK, SHALL go to HOLD; in HOLD, SHALL return to IDLE only on an edge where mem_rd_n=1 and mem_wr_n=1, so one strobe assertion yields exactly one access.
REQ-022 Strobe or address changes during WAIT/ACK/HOLD SHALL be ignored.
REQ-023 Latched address >= DEPTH SHALL produce mem_err=1 with mem_ready; write discarded; read returns all-ones on mem_data_out.
REQ-024 Both strobes low at the sampling edge SHALL produce mem_err=1 with mem_ready; no array access; mem_data_out unchanged.
REQ-025 mem_err SHALL be 0 whenever mem_ready=0.
REQ-026 Address comparison SHALL use the full ADDR_W bits; no aliasing/wrap of out-of-range addresses.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, counter 0, mem_ready=0, mem_err=0, mem_data_out=0.
REQ-028 Reset during WAIT SHALL abort the access; a pending write SHALL NOT reach the array.
REQ-029 The array contents SHALL NOT be cleared by reset.
REQ-030 After rst_n rises, a strobe already held low SHALL be sampled as a new request on the first edge.

Verification (DATA_W=8, ADDR_W=16, DEPTH=1024, WAIT_STATES=2 unless stated)
REQ-031 Write 0xA5 to 0x0010, release, read 0x0010 -> mem_ready pulses 3 cycles after each sampling edge; mem_data_out=0xA5, mem_err=0.
REQ-032 WAIT_STATES=0: read 0x0010 after write 0x3C -> mem_ready on the cycle after the sampling edge; mem_data_out=0x3C.
REQ-033 Read 0x0400 -> mem_ready=1, mem_err=1, mem_data_out=0xFF; write 0x77 to 0x0400, then read 0x0000 -> original 0x0000 contents unchanged.
REQ-034 Hold mem_rd_n=0 for 10 cycles -> exactly one mem_ready pulse; second pulse only after release and re-assert.
REQ-035 Both strobes low at 0x0020 -> mem_err=1 with mem_ready; a following read of 0x0020 returns the prior contents.
REQ-036 Write 0x11 to 0x0030, then write 0x99 to 0x0030 with rst_n pulsed low in WAIT -> outputs 0 immediately; read 0x0030 -> 0x11.
